srec_emitter: RTL and testbench

SREC_EMITTER -- requirements
Module: srec_emitter

---
 rtl/srec_emitter.sv | 210 +++++++++++++++++++++
 tb/tb_srec_emitter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srec_emitter.sv
// rtl/srec_emitter.sv - dumps a word-aligned memory range as Motorola S3 records over a char stream
// One character per valid/ready handshake; records are assembled on the fly from fetched words.
module srec_emitter #(
  parameter int BYTES_PER_REC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [0:31] startAddr,
  input  logic [0:31] endAddr,
  output logic [0:31] memAddr,
  output logic [0:1]  memAccessSize,
  input  logic [0:31] memData,
  output logic [0:7]  txChar,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, HDR, COUNT, ADDR, FETCH, DATA, CSUM, EOL, TERM, DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [31:0] r_rec_addr;
  logic [31:0] r_end;
  logic [31:0] r_mem_addr;
  logic [31:0] r_word;
  logic [7:0]  r_sum;
  logic [7:0]  r_left;
  logic [7:0]  r_tx_char;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic [31:0] w_remain;
  logic [31:0] w_nib_src;
  logic [7:0]  w_n;
  logic [7:0]  w_count;
  logic [7:0]  w_csum;
  logic [7:0]  w_byte;
  logic [7:0]  w_char;
  logic [3:0]  w_nib;
  logic        w_last;
  logic        w_bad;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  // Fixed S7 terminator "S70500000000FA" followed by a line feed.
  function automatic logic [7:0] term_char(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h53;
      4'd1:    return 8'h37;
      4'd3:    return 8'h35;
      4'd12:   return 8'h46;
      4'd13:   return 8'h41;
      4'd14:   return 8'h0A;
      default: return 8'h30;
    endcase
  endfunction

  assign w_bad     = (startAddr[30:31] != 2'b00) || (endAddr[30:31] != 2'b00) ||
                     (endAddr <= startAddr);
  assign w_remain  = r_end - r_rec_addr;
  assign w_n       = (w_remain < 32'(BYTES_PER_REC)) ? w_remain[7:0] : 8'(BYTES_PER_REC);
  assign w_count   = w_n + 8'd5;
  assign w_csum    = ~r_sum;
  assign w_nib_src = (r_state == ADDR) ? r_rec_addr : r_word;
  assign w_nib     = 4'(w_nib_src >> (5'd28 - {r_idx[2:0], 2'b00}));
  assign w_byte    = 8'(w_nib_src >> (5'd24 - {r_idx[2:1], 3'b000}));

  always_comb begin
    w_char = 8'h00;
    w_last = 1'b0;
    case (r_state)
      HDR: begin
        w_char = (r_idx == 4'd0) ? 8'h53 : 8'h33;
        w_last = (r_idx == 4'd1);
      end
      COUNT: begin
        w_char = hex_char((r_idx == 4'd0) ? w_count[7:4] : w_count[3:0]);
        w_last = (r_idx == 4'd1);
      end
      ADDR, DATA: begin
        w_char = hex_char(w_nib);
        w_last = (r_idx == 4'd7);
      end
      CSUM: begin
        w_char = hex_char((r_idx == 4'd0) ? w_csum[7:4] : w_csum[3:0]);
        w_last = (r_idx == 4'd1);
      end
      EOL: begin
        w_char = 8'h0A;
        w_last = 1'b1;
      end
      TERM: begin
        w_char = term_char(r_idx);
        w_last = (r_idx == 4'd14);
      end
      default: begin
        w_char = 8'h00;
        w_last = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= 4'd0;
      r_rec_addr <= 32'd0;
      r_end      <= 32'd0;
      r_mem_addr <= 32'd0;
      r_word     <= 32'd0;
      r_sum      <= 8'd0;
      r_left     <= 8'd0;
      r_tx_char  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            if (w_bad) begin
              r_error <= 1'b1;
            end else begin
              r_rec_addr <= startAddr;
              r_end      <= endAddr;
              r_busy     <= 1'b1;
              r_idx      <= 4'd0;
              r_state    <= HDR;
            end
          end
        end
        // memAddr is shown during idx 0; the synchronous memory answers during idx 1.
        FETCH: begin
          if (r_idx == 4'd0) begin
            r_idx <= 4'd1;
          end else begin
            r_word  <= memData;
            r_idx   <= 4'd0;
            r_state <= DATA;
          end
        end
        default: begin
          if (!r_tx_valid) begin
            r_tx_char  <= w_char;
            r_tx_valid <= 1'b1;
          end else if (txReady) begin
            r_tx_valid <= 1'b0;
            r_idx      <= r_idx + 4'd1;
            if (r_idx[0] && (r_state == ADDR || r_state == DATA))
              r_sum <= r_sum + w_byte;
            if (w_last) begin
              r_idx <= 4'd0;
              case (r_state)
                HDR:   r_state <= COUNT;
                COUNT: begin
                  r_sum   <= w_count;
                  r_state <= ADDR;
                end
                ADDR: begin
                  r_mem_addr <= r_rec_addr;
                  r_left     <= w_n;
                  r_state    <= FETCH;
                end
                DATA: begin
                  r_mem_addr <= r_mem_addr + 32'd4;
                  r_left     <= r_left - 8'd4;
                  r_state    <= (r_left == 8'd4) ? CSUM : FETCH;
                end
                CSUM:  r_state <= EOL;
                EOL: begin
                  r_rec_addr <= r_mem_addr;
                  r_state    <= (r_mem_addr < r_end) ? HDR : TERM;
                end
                TERM: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
                end
                default: r_state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign memAddr       = r_mem_addr;
  assign memAccessSize = 2'b10;
  assign txChar        = r_tx_char;
  assign txValid       = r_tx_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: tb/tb_srec_emitter.sv
// tb/tb_srec_emitter.sv - self-checking bench for srec_emitter against a queue-based S-record model
// Memory is a synchronous-read model; characters are captured on accepted handshakes.
module tb_srec_emitter;

  localparam int BPR = 16;

  typedef struct {
    logic [31:0] sa;
    logic [31:0] ea;
    bit          rejected;
    bit          rr;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        txReady = 1'b1;
  logic [31:0] startAddr = 32'd0;
  logic [31:0] endAddr = 32'd0;
  logic [31:0] memData = 32'd0;
  logic [31:0] memAddr;
  logic [1:0]  memAccessSize;
  logic [7:0]  txChar;
  logic        txValid;
  logic        busy;
  logic        done;
  logic        error;

  int          total = 0;
  int          bad = 0;
  bit          rnd_ready = 1'b0;
  logic [31:0] seed = 32'h5A5A1234;
  logic [7:0]  got[$];
  logic [7:0]  expq[$];
  int          done_cnt = 0;
  int          done_busy = 0;
  int          stall_bad = 0;
  int          valid_seen = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_char = 8'd0;
  vec_t        vecs[$];

  srec_emitter #(.BYTES_PER_REC(BPR)) dut (
    .clock(clock), .reset(reset), .start(start),
    .startAddr(startAddr), .endAddr(endAddr),
    .memAddr(memAddr), .memAccessSize(memAccessSize), .memData(memData),
    .txChar(txChar), .txValid(txValid), .txReady(txReady),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h80020000) return 32'h27BDFFF8;
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  always @(posedge clock) memData <= word_at(memAddr);

  initial begin
    forever begin
      @(posedge clock);
      #1;
      txReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!txValid || txChar !== prev_char)) stall_bad++;
      if (txValid && txReady) got.push_back(txChar);
      if (txValid) valid_seen++;
      if (done) done_cnt++;
      if (done && busy) done_busy++;
      prev_stall = txValid && !txReady;
      prev_char  = txChar;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string h = "0123456789ABCDEF";
    return h.getc(int'(n));
  endfunction

  task automatic push_byte(input logic [7:0] b);
    expq.push_back(hexc(b[7:4]));
    expq.push_back(hexc(b[3:0]));
  endtask

  task automatic build_exp(input logic [31:0] sa, input logic [31:0] ea);
    logic [31:0] a;
    logic [31:0] n;
    logic [31:0] d;
    logic [7:0]  s;
    string term = "S70500000000FA\n";
    expq.delete();
    a = sa;
    while (a < ea) begin
      n = (ea - a < BPR) ? ea - a : BPR;
      expq.push_back(8'h53);
      expq.push_back(8'h33);
      s = 8'(n + 5);
      push_byte(s);
      for (int k = 0; k < 4; k++) begin
        push_byte(a[31-8*k -: 8]);
        s += a[31-8*k -: 8];
      end
      for (int w = 0; w < int'(n / 4); w++) begin
        d = word_at(a + 32'(4 * w));
        for (int k = 0; k < 4; k++) begin
          push_byte(d[31-8*k -: 8]);
          s += d[31-8*k -: 8];
        end
      end
      push_byte(~s);
      expq.push_back(8'h0A);
      a += n;
    end
    for (int i = 0; i < term.len(); i++) expq.push_back(term.getc(i));
  endtask

  task automatic check_stream(input string name);
    int first;
    first = -1;
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      if (first < 0 && got[i] !== expq[i]) first = i;
    total++;
    if (first >= 0 || got.size() != expq.size()) begin
      bad++;
      if (first >= 0)
        $display("FAIL %s: char %0d got %02h want %02h (len %0d want %0d)",
                 name, first, got[first], expq[first], got.size(), expq.size());
      else
        $display("FAIL %s: length got %0d want %0d", name, got.size(), expq.size());
    end
  endtask

  task automatic check_literal(input string name, input string lit, input int offset);
    int first;
    first = -1;
    for (int i = 0; i < lit.len(); i++)
      if (first < 0 && (offset + i >= got.size() || got[offset + i] !== lit.getc(i))) first = i;
    total++;
    if (first >= 0) begin
      bad++;
      $display("FAIL %s: mismatch at char %0d of literal (captured %0d chars)",
               name, first, got.size());
    end
  endtask

  task automatic run_dump(input logic [31:0] sa, input logic [31:0] ea, input bit rr,
                          input int restart_at);
    int cyc;
    got.delete();
    done_cnt = 0;
    done_busy = 0;
    stall_bad = 0;
    rnd_ready = rr;
    @(posedge clock); #1;
    startAddr = sa;
    endAddr = ea;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clock); #1;
      cyc++;
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        startAddr = 32'h00002000;
        endAddr = 32'h00002010;
      end
    end
    start = 1'b0;
    check("dump_finished", 32'(done_cnt != 0), 32'd1);
    repeat (4) @(negedge clock);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_low_with_done", 32'(done_busy), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("stall_stable", 32'(stall_bad), 32'd0);
    rnd_ready = 1'b0;
  endtask

  task automatic bad_start(input logic [31:0] sa, input logic [31:0] ea);
    valid_seen = 0;
    @(posedge clock); #1;
    startAddr = sa;
    endAddr = ea;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("err_pulse", 32'(error), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("err_cleared", 32'(error), 32'd0);
    repeat (4) @(negedge clock);
    check("err_no_tx", 32'(valid_seen), 32'd0);
  endtask

  initial begin
    logic [31:0] sa;
    logic [31:0] ea;
    int          wait_cyc;

    seed = $urandom;
    vecs.push_back('{32'h80020000, 32'h80020004, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000014, 1'b0, 1'b0});
    vecs.push_back('{32'h00001000, 32'h00001040, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFF0, 32'hFFFFFFFC, 1'b0, 1'b1});
    vecs.push_back('{32'h80020002, 32'h80020004, 1'b1, 1'b0});
    vecs.push_back('{32'h00000004, 32'h00000007, 1'b1, 1'b0});
    vecs.push_back('{32'h00000010, 32'h00000010, 1'b1, 1'b0});
    vecs.push_back('{32'h00000020, 32'h00000010, 1'b1, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 1'b0});

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_txValid", 32'(txValid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_memAddr", memAddr, 32'd0);
    check("rst_txChar", 32'(txChar), 32'd0);
    check("access_size", 32'(memAccessSize), 32'd2);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rejected) begin
        bad_start(vecs[i].sa, vecs[i].ea);
      end else begin
        run_dump(vecs[i].sa, vecs[i].ea, vecs[i].rr, 0);
        build_exp(vecs[i].sa, vecs[i].ea);
        check_stream($sformatf("vec%0d_stream", i));
      end
    end

    run_dump(32'h80020000, 32'h80020004, 1'b0, 0);
    check_literal("single_word_literal", "S3098002000027BDFFF899\nS70500000000FA\n", 0);

    run_dump(32'h00000000, 32'h00000014, 1'b0, 0);
    check_literal("split_rec0_header", "S31500000000", 0);
    check_literal("split_rec1_header", "S30900000010", 47);

    run_dump(32'h80020000, 32'h80020004, 1'b1, 0);
    check_literal("backpressure_literal", "S3098002000027BDFFF899\nS70500000000FA\n", 0);

    for (int r = 0; r < 6; r++) begin
      sa = $urandom & 32'h0FFFFFFC;
      ea = sa + 32'(4 * $urandom_range(1, 24));
      run_dump(sa, ea, 1'b1, 0);
      build_exp(sa, ea);
      check_stream($sformatf("random%0d_stream", r));
    end

    got.delete();
    rnd_ready = 1'b0;
    @(posedge clock); #1;
    startAddr = 32'h00001000;
    endAddr = 32'h00001040;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_cyc = 0;
    while (got.size() < 5 && wait_cyc < 500) begin
      @(posedge clock); #1;
      wait_cyc++;
    end
    check("reset_mid_reached", 32'(got.size() >= 5), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_mid_txValid", 32'(txValid), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    valid_seen = 0;
    repeat (30) @(negedge clock);
    check("reset_mid_no_done", 32'(done_cnt), 32'd0);
    check("reset_mid_quiet", 32'(valid_seen), 32'd0);
    run_dump(32'h80020000, 32'h80020004, 1'b0, 0);
    build_exp(32'h80020000, 32'h80020004);
    check_stream("after_reset_stream");

    run_dump(32'h00001000, 32'h00001040, 1'b0, 40);
    build_exp(32'h00001000, 32'h00001040);
    check_stream("start_while_busy_stream");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
